// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from its own bit-period counter.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_error flag.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] UBRR,
  input  logic        ubrr_changed,
  input  logic        rx,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        frame_error,
  output logic        parity_error,
  output logic        busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e      state_q, state_d;
  logic [11:0] timer_q, timer_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        parity_bad_q, parity_bad_d;
  logic [11:0] p_m1, half, h_m1;
  logic        expired, fall, stop_evt;

  // P-1 = max(UBRR,3); H = P>>1 computed without a 13-bit intermediate
  assign p_m1    = (UBRR < 12'd3) ? 12'd3 : UBRR;
  assign half    = {1'b0, p_m1[11:1]} + {11'd0, p_m1[0]};
  assign h_m1    = half - 12'd1;
  assign expired = (timer_q == 12'd0);
  assign fall    = prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= 12'd0;
      shift_q       <= 8'd0;
      bit_cnt_q     <= 3'd0;
      data_out_q    <= 8'd0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      parity_bad_q  <= 1'b0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      parity_bad_q  <= parity_bad_d;
      sync1_q       <= rx;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    parity_bad_d = parity_bad_q;
    if (ubrr_changed) begin
      state_d = StIdle;
      timer_d = 12'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (fall) begin
            state_d      = StStart;
            timer_d      = h_m1;
            parity_bad_d = 1'b0;
          end
        end
        StStart: begin
          if (!expired) begin
            timer_d = timer_q - 12'd1;
          end else if (!sync2_q) begin
            state_d   = StData;
            timer_d   = p_m1;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = StIdle;
            timer_d = 12'd0;
          end
        end
        StData: begin
          if (!expired) begin
            timer_d = timer_q - 12'd1;
          end else begin
            shift_d   = {sync2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            timer_d   = p_m1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (!expired) begin
            timer_d = timer_q - 12'd1;
          end else begin
            parity_bad_d = (^shift_q) ^ sync2_q;
            state_d      = StStop;
            timer_d      = p_m1;
          end
        end
`endif
        StStop: begin
          if (!expired) begin
            timer_d = timer_q - 12'd1;
          end else begin
            state_d = StIdle;
            timer_d = 12'd0;
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = 12'd0;
        end
      endcase
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    stop_evt      = !ubrr_changed && (state_q == StStop) && expired;
    data_valid_d  = stop_evt && sync2_q && !parity_bad_q;
    frame_error_d = stop_evt && !sync2_q;
    data_out_d    = data_valid_d ? shift_q : data_out_q;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_error_q;
  always_ff @(posedge clk) begin
    if (rst) parity_error_q <= 1'b0;
    else     parity_error_q <= stop_evt && parity_bad_q;
  end
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART peripheral: deserializes 8N1 frames, or 8E1 frames when parity is compiled in, from the `rx` pin. It uses the same 12-bit `UBRR` bit-period register and `ubrr_changed` strobe as the baud generator. The block samples mid-bit from its own bit-period counter and presents each received byte to the CPU-side register file as a one-cycle `data_valid` pulse, with error flags alongside.

## Interface
- No parameters; frame format is fixed at 8 data bits, LSB first, 1 stop bit.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `UBRR` input 12: bit period select. P = UBRR+1 clocks per bit; values below 3 are treated as 3 (P=4).
- `ubrr_changed` input 1: one-cycle strobe; aborts any frame in progress.
- `rx` input 1: asynchronous serial line, idle high.
- `data_out` output 8: last good byte; holds until the next good byte.
- `data_valid` output 1: one-cycle pulse when a frame completes with a good stop bit (and good parity, when compiled in).
- `frame_error` output 1: one-cycle pulse when the stop bit is sampled low.
- `parity_error` output 1: one-cycle pulse on a parity mismatch; constant 0 without the parity macro.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. Start detection is a falling edge on the synchronized line (previous 1, current 0).
- H = P>>1. The bit timer is 12 bits wide and is reloaded on every state entry.
- State IDLE: wait for a falling edge, then go to START.
- State START: H clocks after the edge, sample the line.
  - Sample = 0 → DATA.
  - Sample = 1 → false start; return to IDLE with no flags.
- State DATA: take 8 samples spaced P clocks apart, first one P clocks after the start sample. Shift right into an 8-bit register (LSB first); a 3-bit counter tracks bits. After bit 7, go to PARITY if enabled, else STOP.
- State PARITY: sample P clocks after bit 7. The error condition is (XOR of data ^ sample) ≠ 0, i.e. even parity.
- State STOP: sample P clocks after the last bit.
  - Sample = 1 and no parity error → load `data_out`, pulse `data_valid`.
  - Sample = 0 → pulse `frame_error`; `data_out` unchanged.
  - Parity error with good stop → pulse `parity_error` only.
  - Stop low and parity bad → both error pulses.
  - Return to IDLE in all cases.
- `ubrr_changed` = 1 in any state → IDLE on the next edge, timer cleared, no flags, `data_out` unchanged. This takes priority over every sample event.
- `UBRR` is read on every timer reload; software must pulse `ubrr_changed` after writing it.
- `rst` overrides everything, including mid-frame.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `frame_error`=0, `parity_error`=0, `busy`=0, state IDLE.
- Start detect: falling edge at the `rx` pin is seen 2 clocks later; `busy` rises on the next edge.
- Each sample is taken on the clock edge where the timer expires.
- Result pulses (`data_valid`, `frame_error`, `parity_error`) are registered: high for exactly the 1 cycle after the stop-sample edge. `busy` falls on that same edge.
- Back-to-back frames: a falling edge in the cycle IDLE is re-entered is detected; no idle gap is required beyond the stop bit.
- A line held low after a frame error does not retrigger; a new high→low edge is required.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present; frames are 11 bits (start, 8 data, even parity, stop).
  - `parity_error` is live; `data_valid` is suppressed on a parity mismatch.
- Not defined:
  - PARITY state omitted; frames are 10 bits.
  - `parity_error` is tied 0.

## Test plan
- Reset: assert `rst` mid-frame, UBRR=7 → all outputs at reset values next cycle. A later clean 0x3C frame is received correctly.
- Good byte: UBRR=7 (P=8), send 0xA5 with stop=1 → `data_valid` single pulse, `data_out`=0xA5, `frame_error`=0.
- Framing: send 0x5A with stop=0 → `frame_error` pulse, no `data_valid`, `data_out` keeps its previous value.
- False start: 2-clock low glitch on `rx` (shorter than H=4) → `busy` rises then falls after the START sample, no flags.
- Rate change mid-frame: raise `ubrr_changed` during DATA → IDLE next cycle, no flags. Then set UBRR=15 and send 0xFF → `data_out`=0xFF.
- Parity (macro on): send 0x01 with parity bit 0 → `parity_error` pulse, no `data_valid`. Resend with parity bit 1 → `data_valid`, `data_out`=0x01.
